// File: rtl/time_set_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : time_set_ctrl_pkg
// Purpose : Shared definitions for the time-entry controller: FSM state
//           encodings, per-field BCD maxima and BCD packing offsets of the
//           24-bit {HH,MM,SS} time word.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package time_set_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_SET_H  = 3'd1,
        ST_SET_M  = 3'd2,
        ST_SET_S  = 3'd3,
        ST_COMMIT = 3'd4
    } state_e;

    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;

    // LSB position of each two-digit BCD field inside the 24-bit time word
    localparam int HOUR_LSB = 16;
    localparam int MIN_LSB  = 8;
    localparam int SEC_LSB  = 0;

endpackage : time_set_ctrl_pkg
`default_nettype wire

// File: rtl/time_set_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module  : btn_debounce
// Purpose : Raw push-button conditioner. Two-flop synchroniser, then a
//           stability counter: the synchronised level must differ from the
//           accepted level for DEBOUNCE_CYCLES consecutive samples before it
//           is accepted. A one-cycle pulse fires when a high level is
//           accepted, so holding gives no repeat and a release has to be
//           stable before another press can count.
// Ports   : clk      in  system clock
//           rst      in  synchronous active-high reset
//           i_btn    in  raw button level, active-high
//           o_pulse  out one-cycle pulse on accepted press
// Rev     : 1.0  initial release
// ============================================================================
module btn_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    logic        sync1_q,  sync1_d;
    logic        sync2_q,  sync2_d;
    logic        stable_q, stable_d;
    logic        pulse_q,  pulse_d;
    logic [15:0] cnt_q,    cnt_d;

    always_comb begin
        sync1_d  = i_btn;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        pulse_d  = 1'b0;
        cnt_d    = 16'd0;
        // Any sample agreeing with the accepted level restarts the count
        if (sync2_q != stable_q) begin
            if (({1'b0, cnt_q} + 17'd1) >= {1'b0, DEBOUNCE_CYCLES}) begin
                stable_d = sync2_q;
                pulse_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_pulse = pulse_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : time_set_ctrl
// Purpose : Button-driven HH:MM:SS time entry. A mode press captures the
//           running time, further mode presses step hour -> minute ->
//           second -> commit; inc/dec edit the selected BCD field with
//           wrap-around. Commit issues a one-cycle load of the edited time.
// Ports   : clk         in   system clock
//           rst         in   synchronous active-high reset
//           btn_mode    in   raw mode button
//           btn_inc     in   raw increment button
//           btn_dec     in   raw decrement button
//           cur_time    in   running time, 6 x 4-bit BCD {HH,MM,SS}
//           set_active  out  high while editing (counters hold)
//           load        out  one-cycle strobe, counters take set_time
//           set_time    out  edited time, same packing as cur_time
//           blink_mask  out  {hour,min,sec}, 1 = blank field this half-period
// Rev     : 1.0  initial release
// ============================================================================
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] BLINK_DIV       = 24'd250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic [23:0] cur_time,
    output logic        set_active,
    output logic        load,
    output logic [23:0] set_time,
    output logic [2:0]  blink_mask
);

    // Step a two-digit BCD field by one with wrap. An out-of-range or
    // non-BCD value is replaced by 00 (up) or the field max (down).
    function automatic logic [7:0] bcd_field_step(input logic [7:0] val,
                                                  input logic [7:0] max_val,
                                                  input logic       up);
        logic       valid;
        logic [7:0] res;
        valid = (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) && (val <= max_val);
        if (up) begin
            if (!valid || (val == max_val))  res = 8'h00;
            else if (val[3:0] == 4'd9)       res = {val[7:4] + 4'd1, 4'd0};
            else                             res = {val[7:4], val[3:0] + 4'd1};
        end else begin
            if (!valid || (val == 8'h00))    res = max_val;
            else if (val[3:0] == 4'd0)       res = {val[7:4] - 4'd1, 4'd9};
            else                             res = {val[7:4], val[3:0] - 4'd1};
        end
        return res;
    endfunction

    logic w_mode, w_inc, w_dec, w_step, w_restart, w_editing;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn_mode (
        .clk(clk), .rst(rst), .i_btn(btn_mode), .o_pulse(w_mode)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn_inc (
        .clk(clk), .rst(rst), .i_btn(btn_inc), .o_pulse(w_inc)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn_dec (
        .clk(clk), .rst(rst), .i_btn(btn_dec), .o_pulse(w_dec)
    );

    state_e      state_q,     state_d;
    logic [23:0] set_time_q,  set_time_d;
    logic [23:0] blink_cnt_q, blink_cnt_d;
    logic        blink_q,     blink_d;

    // inc and dec together cancel; mode takes priority over either
    assign w_step    = w_inc ^ w_dec;
    assign w_editing = (state_q == ST_SET_H) || (state_q == ST_SET_M) ||
                       (state_q == ST_SET_S);

    always_comb begin
        state_d    = state_q;
        set_time_d = set_time_q;
        w_restart  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (w_mode) begin
                    state_d    = ST_SET_H;
                    set_time_d = cur_time;
                    w_restart  = 1'b1;
                end
            end
            ST_SET_H, ST_SET_M, ST_SET_S: begin
                if (w_mode) begin
                    w_restart = 1'b1;
                    case (state_q)
                        ST_SET_H: state_d = ST_SET_M;
                        ST_SET_M: state_d = ST_SET_S;
                        default:  state_d = ST_COMMIT;
                    endcase
                end else if (w_step) begin
                    w_restart = 1'b1;
                    case (state_q)
                        ST_SET_H: set_time_d[HOUR_LSB +: 8] =
                            bcd_field_step(set_time_q[HOUR_LSB +: 8], HOUR_MAX, w_inc);
                        ST_SET_M: set_time_d[MIN_LSB +: 8] =
                            bcd_field_step(set_time_q[MIN_LSB +: 8], MINSEC_MAX, w_inc);
                        default:  set_time_d[SEC_LSB +: 8] =
                            bcd_field_step(set_time_q[SEC_LSB +: 8], MINSEC_MAX, w_inc);
                    endcase
                end
            end
            ST_COMMIT: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    // Blink phase: restarts visible on any field change or edit so the
    // user always sees the new value immediately.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (!w_editing || w_restart) begin
            blink_cnt_d = 24'd0;
            blink_d     = 1'b0;
        end else if (blink_cnt_q >= (BLINK_DIV - 24'd1)) begin
            blink_cnt_d = 24'd0;
            blink_d     = ~blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 24'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            set_time_q  <= 24'h000000;
            blink_cnt_q <= 24'd0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            set_time_q  <= set_time_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign set_active = (state_q != ST_RUN);
    assign load       = (state_q == ST_COMMIT);
    assign set_time   = set_time_q;
    assign blink_mask = {blink_q && (state_q == ST_SET_H),
                         blink_q && (state_q == ST_SET_M),
                         blink_q && (state_q == ST_SET_S)};

endmodule : time_set_ctrl
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_time_set_ctrl
// Purpose : Self-checking bench for time_set_ctrl with directed scenarios
//           and random button sequences against an integer-arithmetic
//           reference of the time-entry behaviour.
// Rev     : 1.0  initial release
// ============================================================================
module tb_time_set_ctrl;

    localparam int DBC  = 4;
    localparam int BDIV = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_mode, btn_inc, btn_dec;
    logic [23:0] cur_time;
    logic        set_active, load;
    logic [23:0] set_time;
    logic [2:0]  blink_mask;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES(16'd4),
        .BLINK_DIV      (24'd8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .cur_time  (cur_time),
        .set_active(set_active),
        .load      (load),
        .set_time  (set_time),
        .blink_mask(blink_mask)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (0=run, 1=hour, 2=min, 3=sec) -------
    int          ref_state = 0;
    logic [23:0] ref_time  = 24'h0;
    int          exp_loads = 0;

    function automatic int b2i(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] i2b(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    function automatic logic [7:0] fstep(input logic [7:0] v, input int maxn, input bit up);
        int n;
        n = b2i(v);
        if (up) return i2b((n + 1) % (maxn + 1));
        return i2b((n + maxn) % (maxn + 1));
    endfunction

    task automatic model(input bit m, input bit i, input bit d);
        int lsb, maxn;
        if (ref_state == 0) begin
            if (m) begin
                ref_state = 1;
                ref_time  = cur_time;
            end
        end else if (m) begin
            if (ref_state == 3) begin
                ref_state = 0;
                exp_loads++;
            end else begin
                ref_state++;
            end
        end else if (i != d) begin
            lsb  = (ref_state == 1) ? 16 : (ref_state == 2) ? 8 : 0;
            maxn = (ref_state == 1) ? 23 : 59;
            ref_time[lsb +: 8] = fstep(ref_time[lsb +: 8], maxn, i);
        end
    endtask

    // ---------------- per-cycle monitor ----------------------------------
    int          load_seen      = 0;
    logic        prev_load      = 1'b0;
    logic [23:0] prev_set_time  = 24'h0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (prev_load) begin
            chk("load_one_cycle", 32'(load), 32'd0);
            chk("active_after_load", 32'(set_active), 32'd0);
        end
        if (load === 1'b1) load_seen++;
        if (set_active === 1'b1 && set_time !== prev_set_time)
            chk("mask_restart", 32'(blink_mask), 32'd0);
        prev_load     = (load === 1'b1);
        prev_set_time = set_time;
    endtask

    task automatic press(input bit m, input bit i, input bit d);
        btn_mode = m; btn_inc = i; btn_dec = d;
        repeat (DBC + 3) tick();
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        repeat (DBC + 6) tick();
        model(m, i, d);
        chk("set_time", 32'(set_time), 32'(ref_time));
        chk("set_active", 32'(set_active), 32'(ref_state != 0));
        chk("load_count", 32'(load_seen), 32'(exp_loads));
    endtask

    function automatic logic [23:0] rand_time();
        return {i2b(int'($urandom_range(0, 23))), i2b(int'($urandom_range(0, 59))),
                i2b(int'($urandom_range(0, 59)))};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          last_tog;
        logic        prev_b;
        logic [1:0]  other_or;
        logic [23:0] hold_t;
        int          guard;

        rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        cur_time = 24'h123456;
        repeat (3) tick();
        chk("rst_set_time", 32'(set_time), 32'h0);
        chk("rst_active", 32'(set_active), 32'd0);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_mask", 32'(blink_mask), 32'd0);
        rst = 1'b0;
        tick();

        // entry latency: press -> pulse (2+DBC) -> state update one edge later
        btn_mode = 1'b1;
        lat = 0;
        while (set_active !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk("entry_latency", 32'(lat), 32'(DBC + 3));
        repeat (3) tick();
        btn_mode = 1'b0;
        repeat (DBC + 6) tick();
        model(1'b1, 1'b0, 1'b0);
        chk("capture", 32'(set_time), 32'h123456);
        press(1, 0, 0);
        press(1, 0, 0);
        press(1, 0, 0);
        chk("exit_loads", 32'(load_seen), 32'd1);
        chk("exit_time", 32'(set_time), 32'h123456);

        // hour wrap and blink
        cur_time = 24'h233456;
        press(1, 0, 0);
        prev_b = blink_mask[2]; last_tog = -1; other_or = 2'b00;
        for (int k = 0; k < 34; k++) begin
            tick();
            other_or |= blink_mask[1:0];
            if (blink_mask[2] !== prev_b) begin
                if (last_tog >= 0) chk("blink_period", 32'(k - last_tog), 32'(BDIV));
                last_tog = k;
            end
            prev_b = blink_mask[2];
        end
        chk("blink_toggled", 32'(last_tog >= 0), 32'd1);
        chk("blink_others", 32'(other_or), 32'd0);
        press(0, 1, 0);
        chk("hour_inc_wrap", 32'(set_time), 32'h003456);
        press(0, 0, 1);
        chk("hour_dec_wrap", 32'(set_time), 32'h233456);
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);

        // minute carry and wrap
        cur_time = 24'h120956;
        press(1, 0, 0); press(1, 0, 0);
        press(0, 1, 0);
        chk("min_carry", 32'(set_time), 32'h121056);
        press(1, 0, 0); press(1, 0, 0);
        cur_time = 24'h125900;
        press(1, 0, 0); press(1, 0, 0);
        press(0, 1, 0);
        chk("min_inc_wrap", 32'(set_time), 32'h120000);
        press(0, 0, 1);
        chk("min_dec_wrap", 32'(set_time), 32'h125900);
        press(1, 0, 0); press(1, 0, 0);

        // conflicts and glitch
        cur_time = 24'h071530;
        press(1, 0, 0);
        press(0, 1, 1);
        chk("incdec_nochange", 32'(set_time), 32'h071530);
        press(1, 1, 0);
        chk("mode_wins", 32'(set_time), 32'h071530);
        press(0, 1, 0);
        chk("after_mode_inc", 32'(set_time), 32'h071630);
        hold_t = set_time;
        btn_inc = 1'b1;
        repeat (3) tick();
        btn_inc = 1'b0;
        repeat (DBC + 6) tick();
        chk("glitch", 32'(set_time), 32'(hold_t));

        // reset mid-edit in seconds field
        guard = 0;
        while (ref_state != 3 && guard < 5) begin
            press(1, 0, 0);
            guard++;
        end
        chk("in_set_s", 32'(ref_state), 32'd3);
        rst = 1'b1;
        tick();
        chk("midrst_active", 32'(set_active), 32'd0);
        chk("midrst_time", 32'(set_time), 32'h0);
        chk("midrst_load", 32'(load), 32'd0);
        chk("midrst_mask", 32'(blink_mask), 32'd0);
        rst = 1'b0;
        ref_state = 0; ref_time = 24'h0;
        tick();
        chk("midrst_no_load", 32'(load_seen), 32'(exp_loads));

        // random button sequences
        for (int n = 0; n < 60; n++) begin
            int op;
            if (ref_state == 0 && $urandom_range(0, 1) == 1) cur_time = rand_time();
            op = int'($urandom_range(0, 7));
            case (op)
                0, 1:    press(1, 0, 0);
                2, 3:    press(0, 1, 0);
                4, 5:    press(0, 0, 1);
                6:       press(0, 1, 1);
                default: press(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            endcase
        end
        guard = 0;
        while (ref_state != 0 && guard < 5) begin
            press(1, 0, 0);
            guard++;
        end
        chk("final_run", 32'(set_active), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_time_set_ctrl
`default_nettype wire
